tl_source_arbiter: RTL and testbench

TL_SOURCE_ARBITER -- requirements
Module: tl_source_arbiter

---
 rtl/tl_source_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_tl_source_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tl_source_arbiter.sv
// tl_source_arbiter
//   Merges two TileLink-UL requester ports onto one shared A/D port.
//   A channel: round-robin between eligible requesters, with a per-port credit
//   limit (MAX_INFLIGHT outstanding requests) and a burst lock so that both
//   beats of a 2-beat Put stay together. The granted port index is prepended to
//   the forwarded source ID.
//   D channel: responses are steered back by the top source bit, combinationally.
//   A 1-bit beat counter per port finds the last beat of 2-beat AccessAckData so
//   the credit is returned only once the whole response has been consumed.
//
// Ports
//   clock, reset            sole clock, asynchronous active-high reset
//   inN_a_*                 A channel from requester N (N = 0, 1)
//   inN_d_*                 D channel to requester N
//   out_a_*                 A channel to the shared port (source is 5 bits)
//   out_d_*                 D channel from the shared port (source[4] = port)
//   err                     sticky flag: a response arrived with no credit out
module tl_source_arbiter #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        in0_a_valid,
  output logic        in0_a_ready,
  input  logic [2:0]  in0_a_bits_opcode,
  input  logic [2:0]  in0_a_bits_param,
  input  logic [2:0]  in0_a_bits_size,
  input  logic [3:0]  in0_a_bits_source,
  input  logic [11:0] in0_a_bits_address,
  input  logic [3:0]  in0_a_bits_mask,
  input  logic [31:0] in0_a_bits_data,
  input  logic        in0_a_bits_corrupt,
  output logic        in0_d_valid,
  input  logic        in0_d_ready,
  output logic [2:0]  in0_d_bits_opcode,
  output logic [2:0]  in0_d_bits_size,
  output logic [3:0]  in0_d_bits_source,
  output logic [31:0] in0_d_bits_data,

  input  logic        in1_a_valid,
  output logic        in1_a_ready,
  input  logic [2:0]  in1_a_bits_opcode,
  input  logic [2:0]  in1_a_bits_param,
  input  logic [2:0]  in1_a_bits_size,
  input  logic [3:0]  in1_a_bits_source,
  input  logic [11:0] in1_a_bits_address,
  input  logic [3:0]  in1_a_bits_mask,
  input  logic [31:0] in1_a_bits_data,
  input  logic        in1_a_bits_corrupt,
  output logic        in1_d_valid,
  input  logic        in1_d_ready,
  output logic [2:0]  in1_d_bits_opcode,
  output logic [2:0]  in1_d_bits_size,
  output logic [3:0]  in1_d_bits_source,
  output logic [31:0] in1_d_bits_data,

  output logic        out_a_valid,
  input  logic        out_a_ready,
  output logic [2:0]  out_a_bits_opcode,
  output logic [2:0]  out_a_bits_param,
  output logic [2:0]  out_a_bits_size,
  output logic [4:0]  out_a_bits_source,
  output logic [11:0] out_a_bits_address,
  output logic [3:0]  out_a_bits_mask,
  output logic [31:0] out_a_bits_data,
  output logic        out_a_bits_corrupt,

  input  logic        out_d_valid,
  output logic        out_d_ready,
  input  logic [2:0]  out_d_bits_opcode,
  input  logic [2:0]  out_d_bits_size,
  input  logic [4:0]  out_d_bits_source,
  input  logic [31:0] out_d_bits_data,

  output logic        err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam logic [2:0] MAX_C    = 3'(MAX_INFLIGHT);

  // PutFull/PutPartial of size 3 carry 8 bytes over a 4-byte bus.
  function automatic logic a_two_beat(input logic [2:0] op, input logic [2:0] size);
    return ((op == 3'd0) || (op == 3'd1)) && (size == 3'd3);
  endfunction

  // AccessAckData of size 3 returns two data beats.
  function automatic logic d_two_beat(input logic [2:0] op, input logic [2:0] size);
    return (op == 3'd1) && (size == 3'd3);
  endfunction

  logic [0:0]      state;
  logic            rr;
  logic            lock;
  logic [1:0][2:0] outst;
  logic [1:0][2:0] outst_nxt;
  logic [1:0]      dbeat;

  logic [1:0]      a_valid;
  logic [1:0]      elig;
  logic            gnt;
  logic            gnt_vld;
  logic            a_fire;
  logic            a_first;
  logic            d_port;
  logic            d_fire;
  logic            d_last;
  logic [1:0]      inc;
  logic [1:0]      dec_req;

  assign a_valid = {in1_a_valid, in0_a_valid};
  assign elig[0] = in0_a_valid && (outst[0] < MAX_C);
  assign elig[1] = in1_a_valid && (outst[1] < MAX_C);

  // Grant selection: the burst lock overrides eligibility and credit.
  always_comb begin
    gnt     = 1'b0;
    gnt_vld = 1'b0;
    if (state == ST_BURST) begin
      gnt     = lock;
      gnt_vld = 1'b1;
    end else if (elig[0] && elig[1]) begin
      gnt     = rr;
      gnt_vld = 1'b1;
    end else if (elig[0]) begin
      gnt     = 1'b0;
      gnt_vld = 1'b1;
    end else if (elig[1]) begin
      gnt     = 1'b1;
      gnt_vld = 1'b1;
    end
  end

  assign out_a_valid = gnt_vld && a_valid[gnt];
  assign in0_a_ready = gnt_vld && !gnt && out_a_ready;
  assign in1_a_ready = gnt_vld &&  gnt && out_a_ready;

  assign out_a_bits_opcode  = gnt ? in1_a_bits_opcode  : in0_a_bits_opcode;
  assign out_a_bits_param   = gnt ? in1_a_bits_param   : in0_a_bits_param;
  assign out_a_bits_size    = gnt ? in1_a_bits_size    : in0_a_bits_size;
  assign out_a_bits_source  = {gnt, (gnt ? in1_a_bits_source : in0_a_bits_source)};
  assign out_a_bits_address = gnt ? in1_a_bits_address : in0_a_bits_address;
  assign out_a_bits_mask    = gnt ? in1_a_bits_mask    : in0_a_bits_mask;
  assign out_a_bits_data    = gnt ? in1_a_bits_data    : in0_a_bits_data;
  assign out_a_bits_corrupt = gnt ? in1_a_bits_corrupt : in0_a_bits_corrupt;

  assign a_fire  = out_a_valid && out_a_ready;
  assign a_first = a_fire && (state == ST_IDLE);

  // D routing: steered by the port bit the A side prepended to the source.
  assign d_port            = out_d_bits_source[4];
  assign in0_d_valid       = out_d_valid && !d_port;
  assign in1_d_valid       = out_d_valid &&  d_port;
  assign out_d_ready       = d_port ? in1_d_ready : in0_d_ready;
  assign in0_d_bits_opcode = out_d_bits_opcode;
  assign in0_d_bits_size   = out_d_bits_size;
  assign in0_d_bits_source = out_d_bits_source[3:0];
  assign in0_d_bits_data   = out_d_bits_data;
  assign in1_d_bits_opcode = out_d_bits_opcode;
  assign in1_d_bits_size   = out_d_bits_size;
  assign in1_d_bits_source = out_d_bits_source[3:0];
  assign in1_d_bits_data   = out_d_bits_data;

  assign d_fire = out_d_valid && out_d_ready;
  // A 2-beat response ends on the beat seen while the port's beat bit is set.
  assign d_last = !d_two_beat(out_d_bits_opcode, out_d_bits_size) || dbeat[d_port];

  // Credit bookkeeping: simultaneous issue and completion cancel out; a
  // completion with no credit outstanding is ignored here and flagged as err.
  always_comb begin
    outst_nxt = outst;
    for (int i = 0; i < 2; i++) begin
      inc[i]     = a_first && (gnt == 1'(i));
      dec_req[i] = d_fire && d_last && (d_port == 1'(i));
      if (inc[i] && !(dec_req[i] && (outst[i] != 3'd0)))
        outst_nxt[i] = outst[i] + 3'd1;
      else if (!inc[i] && dec_req[i] && (outst[i] != 3'd0))
        outst_nxt[i] = outst[i] - 3'd1;
    end
  end

  // Registered state: arbitration, burst lock, credits, D beat tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      rr    <= 1'b0;
      lock  <= 1'b0;
      outst <= '0;
      dbeat <= '0;
      err   <= 1'b0;
    end else begin
      if (a_fire) begin
        if (state == ST_IDLE) begin
          rr <= !gnt;
          if (a_two_beat(out_a_bits_opcode, out_a_bits_size)) begin
            state <= ST_BURST;
            lock  <= gnt;
          end
        end else begin
          state <= ST_IDLE;
        end
      end
      if (d_fire && d_two_beat(out_d_bits_opcode, out_d_bits_size))
        dbeat[d_port] <= !dbeat[d_port];
      outst <= outst_nxt;
      if ((dec_req[0] && (outst[0] == 3'd0)) || (dec_req[1] && (outst[1] == 3'd0)))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tl_source_arbiter.sv
// tb_tl_source_arbiter
//   Randomized bench for tl_source_arbiter. A transaction-level reference model
//   (outstanding request counts, beats left in the current A burst and in the
//   current D response per port, round-robin favourite, sticky error) predicts
//   every output each cycle. Inputs change 1 ns after the rising edge; outputs
//   are compared at the falling edge and the model advances there. Occasional
//   asynchronous reset pulses land mid-traffic.
module tb_tl_source_arbiter;

  localparam int MAX    = 4;
  localparam int CYCLES = 4000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        a_valid   [2];
  logic        a_ready   [2];
  logic [2:0]  a_op      [2];
  logic [2:0]  a_param   [2];
  logic [2:0]  a_size    [2];
  logic [3:0]  a_src     [2];
  logic [11:0] a_addr    [2];
  logic [3:0]  a_mask    [2];
  logic [31:0] a_data    [2];
  logic        a_corrupt [2];
  logic        d_valid_o [2];
  logic        d_ready   [2];
  logic [2:0]  d_op_o    [2];
  logic [2:0]  d_size_o  [2];
  logic [3:0]  d_src_o   [2];
  logic [31:0] d_data_o  [2];

  logic        out_a_valid, out_a_ready, oa_corrupt;
  logic [2:0]  oa_op, oa_param, oa_size;
  logic [4:0]  oa_src;
  logic [11:0] oa_addr;
  logic [3:0]  oa_mask;
  logic [31:0] oa_data;
  logic        out_d_valid, out_d_ready;
  logic [2:0]  od_op, od_size;
  logic [4:0]  od_src;
  logic [31:0] od_data;
  logic        err;

  tl_source_arbiter #(.MAX_INFLIGHT(MAX)) dut (
    .clock(clock), .reset(reset),
    .in0_a_valid(a_valid[0]), .in0_a_ready(a_ready[0]),
    .in0_a_bits_opcode(a_op[0]), .in0_a_bits_param(a_param[0]), .in0_a_bits_size(a_size[0]),
    .in0_a_bits_source(a_src[0]), .in0_a_bits_address(a_addr[0]), .in0_a_bits_mask(a_mask[0]),
    .in0_a_bits_data(a_data[0]), .in0_a_bits_corrupt(a_corrupt[0]),
    .in0_d_valid(d_valid_o[0]), .in0_d_ready(d_ready[0]),
    .in0_d_bits_opcode(d_op_o[0]), .in0_d_bits_size(d_size_o[0]),
    .in0_d_bits_source(d_src_o[0]), .in0_d_bits_data(d_data_o[0]),
    .in1_a_valid(a_valid[1]), .in1_a_ready(a_ready[1]),
    .in1_a_bits_opcode(a_op[1]), .in1_a_bits_param(a_param[1]), .in1_a_bits_size(a_size[1]),
    .in1_a_bits_source(a_src[1]), .in1_a_bits_address(a_addr[1]), .in1_a_bits_mask(a_mask[1]),
    .in1_a_bits_data(a_data[1]), .in1_a_bits_corrupt(a_corrupt[1]),
    .in1_d_valid(d_valid_o[1]), .in1_d_ready(d_ready[1]),
    .in1_d_bits_opcode(d_op_o[1]), .in1_d_bits_size(d_size_o[1]),
    .in1_d_bits_source(d_src_o[1]), .in1_d_bits_data(d_data_o[1]),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_a_bits_opcode(oa_op), .out_a_bits_param(oa_param), .out_a_bits_size(oa_size),
    .out_a_bits_source(oa_src), .out_a_bits_address(oa_addr), .out_a_bits_mask(oa_mask),
    .out_a_bits_data(oa_data), .out_a_bits_corrupt(oa_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
    .out_d_bits_opcode(od_op), .out_d_bits_size(od_size),
    .out_d_bits_source(od_src), .out_d_bits_data(od_data),
    .err(err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  int m_out    [2];
  int m_d_left [2];
  int m_a_left;
  int m_lock;
  int m_rr;
  bit m_err;
  // Grant prediction of the current cycle, reused by the model step
  int x_g;
  bit x_av;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int a_beats(input logic [2:0] op, input logic [2:0] size);
    return (op <= 3'd1 && size == 3'd3) ? 2 : 1;
  endfunction

  function automatic int d_beats(input logic [2:0] op, input logic [2:0] size);
    return (op == 3'd1 && size == 3'd3) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_out[0] = 0; m_out[1] = 0;
    m_d_left[0] = 0; m_d_left[1] = 0;
    m_a_left = 0; m_lock = 0; m_rr = 0; m_err = 1'b0;
  endtask

  task automatic check_outputs();
    bit e0, e1, gv;
    int g, p;
    if (m_a_left > 0) begin
      g = m_lock; gv = 1'b1;
    end else begin
      e0 = a_valid[0] && (m_out[0] < MAX);
      e1 = a_valid[1] && (m_out[1] < MAX);
      gv = e0 || e1;
      g  = (e0 && e1) ? m_rr : (e0 ? 0 : 1);
    end
    x_g  = g;
    x_av = gv && a_valid[g];
    check_val("out_a_valid", 64'(out_a_valid), 64'(x_av));
    check_val("in0_a_ready", 64'(a_ready[0]), 64'(gv && g == 0 && out_a_ready));
    check_val("in1_a_ready", 64'(a_ready[1]), 64'(gv && g == 1 && out_a_ready));
    if (x_av) begin
      check_val("out_a_source", 64'(oa_src), 64'({g[0], a_src[g]}));
      check_val("out_a_payload",
                64'({oa_op, oa_param, oa_size, oa_addr, oa_mask, oa_data, oa_corrupt}),
                64'({a_op[g], a_param[g], a_size[g], a_addr[g], a_mask[g], a_data[g], a_corrupt[g]}));
    end
    p = int'(od_src[4]);
    check_val("in0_d_valid", 64'(d_valid_o[0]), 64'(out_d_valid && p == 0));
    check_val("in1_d_valid", 64'(d_valid_o[1]), 64'(out_d_valid && p == 1));
    check_val("out_d_ready", 64'(out_d_ready), 64'(d_ready[p]));
    for (int q = 0; q < 2; q++)
      check_val(q == 0 ? "in0_d_payload" : "in1_d_payload",
                64'({d_op_o[q], d_size_o[q], d_src_o[q], d_data_o[q]}),
                64'({od_op, od_size, od_src[3:0], od_data}));
    check_val("err", 64'(err), 64'(m_err));
  endtask

  // Advance the model by one clock using the inputs now applied.
  task automatic model_step();
    int p;
    p = int'(od_src[4]);
    if (out_d_valid && d_ready[p]) begin
      if (m_d_left[p] == 0) m_d_left[p] = d_beats(od_op, od_size);
      m_d_left[p]--;
      if (m_d_left[p] == 0) begin
        if (m_out[p] == 0) m_err = 1'b1;
        else m_out[p]--;
      end
    end
    if (x_av && out_a_ready) begin
      if (m_a_left > 0) begin
        m_a_left--;
      end else begin
        m_out[x_g]++;
        m_rr     = 1 - x_g;
        m_lock   = x_g;
        m_a_left = a_beats(a_op[x_g], a_size[x_g]) - 1;
      end
    end
  endtask

  task automatic drive_random(input int d_rate);
    int p;
    for (int i = 0; i < 2; i++) begin
      a_valid[i]   = ($urandom_range(0, 99) < 65);
      case ($urandom_range(0, 3))
        0:       a_op[i] = 3'd0;
        1:       a_op[i] = 3'd1;
        default: a_op[i] = 3'($urandom_range(0, 7));
      endcase
      a_size[i]    = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'($urandom_range(0, 7));
      a_param[i]   = 3'($urandom);
      a_src[i]     = 4'($urandom);
      a_addr[i]    = 12'($urandom);
      a_mask[i]    = 4'($urandom);
      a_data[i]    = $urandom;
      a_corrupt[i] = 1'($urandom);
      d_ready[i]   = ($urandom_range(0, 99) < 80);
    end
    out_a_ready = ($urandom_range(0, 99) < 75);
    od_op   = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(0, 7));
    od_size = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'($urandom_range(0, 7));
    od_data = $urandom;
    p = -1;
    if (m_d_left[0] > 0) p = 0;
    else if (m_d_left[1] > 0) p = 1;
    if (p >= 0) begin
      od_op = 3'd1; od_size = 3'd3;
    end else if (m_out[0] > 0 && m_out[1] > 0) p = $urandom_range(0, 1);
    else if (m_out[0] > 0) p = 0;
    else if (m_out[1] > 0) p = 1;
    else if ($urandom_range(0, 99) < 3) p = $urandom_range(0, 1);
    out_d_valid = (p >= 0) && ($urandom_range(0, 99) < d_rate);
    od_src = {(p == 1), 4'($urandom)};
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      a_valid[i] = 1'b0; a_op[i] = '0; a_param[i] = '0; a_size[i] = '0; a_src[i] = '0;
      a_addr[i] = '0; a_mask[i] = '0; a_data[i] = '0; a_corrupt[i] = 1'b0; d_ready[i] = 1'b0;
    end
    out_a_ready = 1'b0; out_d_valid = 1'b0;
    od_op = '0; od_size = '0; od_src = '0; od_data = '0;
    model_reset();
    #3;
    check_outputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (cyc = 0; cyc < CYCLES; cyc++) begin
      // alternate between heavy D return and starved D to reach the credit limit
      drive_random(((cyc / 400) % 2 == 1) ? 8 : 45);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        model_reset();
        #1 check_outputs();
      end
      @(negedge clock);
      check_outputs();
      if (!reset) model_step();
      @(posedge clock);
      #1 reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
